// File: rtl/hsi_accel_pkg.sv
// Shared types and constants for the HSI accelerator job sequencer.
package hsi_accel_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DRAIN,
    S_NEXT,
    S_DONE,
    S_ERROR
  } seq_state_e;

  localparam logic [7:0] ERR_TIMEOUT = 8'hFE;
  localparam logic [7:0] ERR_BAD_CFG = 8'hFF;

endpackage

// File: rtl/hsi_pixel_sequencer.sv
// Job-level controller: streams per-pixel input words into the vector core, kicks it,
// waits for completion and drains result words to the output stream, once per pixel.
module hsi_pixel_sequencer
  import hsi_accel_pkg::*;
#(
  parameter int OP_CODE_WIDTH   = 8,
  parameter int NUM_BANDS_WIDTH = 8,
  parameter int ERR_WIDTH       = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int PIX_CNT_WIDTH   = 16,
  parameter int WORDS_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       job_start_i,
  input  logic                       abort_i,
  input  logic [OP_CODE_WIDTH-1:0]   op_code_i,
  input  logic [NUM_BANDS_WIDTH-1:0] num_bands_i,
  input  logic [PIX_CNT_WIDTH-1:0]   num_pixels_i,
  input  logic [WORDS_WIDTH-1:0]     in_words_i,
  input  logic [WORDS_WIDTH-1:0]     out_words_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [ERR_WIDTH-1:0]       err_code_o,
  output logic [PIX_CNT_WIDTH-1:0]   pixel_cnt_o,
  input  logic                       s_valid_i,
  output logic                       s_ready_o,
  input  logic [DATA_WIDTH-1:0]      s_data_i,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [DATA_WIDTH-1:0]      m_data_o,
  output logic [OP_CODE_WIDTH-1:0]   core_op_code_o,
  output logic [NUM_BANDS_WIDTH-1:0] core_num_bands_o,
  output logic                       core_start_o,
  output logic                       core_in_wr_en_o,
  output logic [DATA_WIDTH-1:0]      core_in_data_o,
  output logic                       core_out_rd_en_o,
  input  logic [DATA_WIDTH-1:0]      core_out_data_i,
  input  logic                       core_out_valid_i,
  input  logic                       core_pixel_done_i,
  input  logic [ERR_WIDTH-1:0]       core_error_code_i
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_e                 state_q, state_d;
  logic [OP_CODE_WIDTH-1:0]   op_q;
  logic [NUM_BANDS_WIDTH-1:0] bands_q;
  logic [PIX_CNT_WIDTH-1:0]   pix_total_q, pix_cnt_q;
  logic [WORDS_WIDTH-1:0]     in_words_q, out_words_q, word_cnt_q;
  logic [TO_W-1:0]            to_cnt_q;
  logic                       err_q;
  logic [ERR_WIDTH-1:0]       err_code_q;

  logic accept, bad_cfg, push, pop, last_push, last_pop, to_expire;

  assign accept    = (state_q == S_IDLE) && job_start_i;
  assign bad_cfg   = (num_pixels_i == '0) || (in_words_i == '0);

  // Abort suppresses handshakes in its own cycle so no word is half-transferred.
  assign s_ready_o = (state_q == S_LOAD) && !abort_i;
  assign push      = s_valid_i && s_ready_o;
  assign m_valid_o = (state_q == S_DRAIN) && !abort_i && core_out_valid_i;
  assign pop       = m_valid_o && m_ready_i;
  assign last_push = push && (word_cnt_q + 1'b1 == in_words_q);
  assign last_pop  = pop && (word_cnt_q + 1'b1 == out_words_q);
  assign to_expire = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  assign m_data_o         = (state_q == S_DRAIN) ? core_out_data_i : '0;
  assign core_in_wr_en_o  = push;
  assign core_in_data_o   = s_data_i;
  assign core_out_rd_en_o = pop;
  assign core_start_o     = (state_q == S_START) && !abort_i;
  assign core_op_code_o   = op_q;
  assign core_num_bands_o = bands_q;
  assign busy_o           = (state_q == S_LOAD) || (state_q == S_START) || (state_q == S_WAIT) ||
                            (state_q == S_DRAIN) || (state_q == S_NEXT);
  assign done_o           = (state_q == S_DONE);
  assign err_o            = err_q;
  assign err_code_o       = err_code_q;
  assign pixel_cnt_o      = pix_cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (job_start_i) state_d = bad_cfg ? S_ERROR : S_LOAD;
      S_LOAD:  if (last_push) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        // A completion landing on the expiry cycle still counts as success.
        if (core_pixel_done_i) begin
          if (core_error_code_i != '0)  state_d = S_ERROR;
          else if (out_words_q == '0)   state_d = S_NEXT;
          else                          state_d = S_DRAIN;
        end else if (to_expire) begin
          state_d = S_ERROR;
        end
      end
      S_DRAIN: if (last_pop) state_d = S_NEXT;
      S_NEXT:  state_d = (pix_cnt_q + 1'b1 == pix_total_q) ? S_DONE : S_LOAD;
      default: state_d = S_IDLE;
    endcase
    if (abort_i && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      bands_q     <= '0;
      pix_total_q <= '0;
      in_words_q  <= '0;
      out_words_q <= '0;
      pix_cnt_q   <= '0;
      word_cnt_q  <= '0;
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q        <= op_code_i;
        bands_q     <= num_bands_i;
        pix_total_q <= num_pixels_i;
        in_words_q  <= in_words_i;
        out_words_q <= out_words_i;
        pix_cnt_q   <= '0;
        err_q       <= bad_cfg;
        err_code_q  <= bad_cfg ? ERR_WIDTH'(ERR_BAD_CFG) : '0;
      end
      if ((state_q == S_WAIT) && (state_d == S_ERROR)) begin
        err_q      <= 1'b1;
        err_code_q <= core_pixel_done_i ? core_error_code_i : ERR_WIDTH'(ERR_TIMEOUT);
      end
      if ((state_q == S_NEXT) && !abort_i && (pix_cnt_q != pix_total_q))
        pix_cnt_q <= pix_cnt_q + 1'b1;
      // One word counter serves both LOAD pushes and DRAIN pops; any state change rewinds it.
      word_cnt_q <= (state_d != state_q) ? '0 : word_cnt_q + WORDS_WIDTH'(push | pop);
      to_cnt_q   <= (state_q == S_WAIT) ? to_cnt_q + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_hsi_pixel_sequencer.sv
// Bench for hsi_pixel_sequencer: behavioural core model plus per-scenario checks.
`timescale 1ns/1ps
module tb_hsi_pixel_sequencer;
  localparam int DW = 32, PW = 16, WW = 10, EW = 8, OW = 8, BW = 8, TO = 16;

  logic          clk_i = 1'b0, rst_ni = 1'b0;
  logic          job_start_i = 1'b0, abort_i = 1'b0;
  logic [OW-1:0] op_code_i = '0;
  logic [BW-1:0] num_bands_i = '0;
  logic [PW-1:0] num_pixels_i = '0;
  logic [WW-1:0] in_words_i = '0, out_words_i = '0;
  logic          busy_o, done_o, err_o;
  logic [EW-1:0] err_code_o;
  logic [PW-1:0] pixel_cnt_o;
  logic          s_valid_i = 1'b0, s_ready_o;
  logic [DW-1:0] s_data_i = '0;
  logic          m_valid_o, m_ready_i = 1'b0;
  logic [DW-1:0] m_data_o;
  logic [OW-1:0] core_op_code_o;
  logic [BW-1:0] core_num_bands_o;
  logic          core_start_o, core_in_wr_en_o, core_out_rd_en_o;
  logic [DW-1:0] core_in_data_o;
  logic [DW-1:0] core_out_data_i = '0;
  logic          core_out_valid_i = 1'b0, core_pixel_done_i = 1'b0;
  logic [EW-1:0] core_error_code_i = '0;

  always #5 clk_i = ~clk_i;

  hsi_pixel_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .job_start_i(job_start_i), .abort_i(abort_i),
    .op_code_i(op_code_i), .num_bands_i(num_bands_i), .num_pixels_i(num_pixels_i),
    .in_words_i(in_words_i), .out_words_i(out_words_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o),
    .pixel_cnt_o(pixel_cnt_o),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .core_op_code_o(core_op_code_o), .core_num_bands_o(core_num_bands_o),
    .core_start_o(core_start_o), .core_in_wr_en_o(core_in_wr_en_o),
    .core_in_data_o(core_in_data_o), .core_out_rd_en_o(core_out_rd_en_o),
    .core_out_data_i(core_out_data_i), .core_out_valid_i(core_out_valid_i),
    .core_pixel_done_i(core_pixel_done_i), .core_error_code_i(core_error_code_i)
  );

  int errors = 0, checks = 0;

  // Scoreboard: what the stream/core saw versus what the bench intended.
  logic [DW-1:0] push_q[$], beat_q[$], res_q[$], exp_in_q[$], exp_out_q[$];
  logic [DW-1:0] w;
  int            start_cnt, done_cnt, viol, wait_cnt, pix_no, core_lat, err_pix, out_words_m;
  logic [EW-1:0] err_val;
  bit            withhold, do_start, do_pop;

  // Monitor at negedge, behavioural core updated just after each posedge.
  always begin
    @(negedge clk_i);
    do_start = 1'b0;
    do_pop   = 1'b0;
    if (rst_ni) begin
      if (core_in_wr_en_o !== (s_valid_i & s_ready_o)) viol++;
      if (core_out_rd_en_o !== (m_valid_o & m_ready_i)) viol++;
      if (m_valid_o && !core_out_valid_i) viol++;
      if (core_in_wr_en_o) push_q.push_back(core_in_data_o);
      if (core_out_rd_en_o) beat_q.push_back(m_data_o);
      if (core_start_o) start_cnt++;
      if (done_o) done_cnt++;
      do_start = core_start_o;
      do_pop   = core_out_rd_en_o;
    end
    @(posedge clk_i);
    #1;
    core_pixel_done_i = 1'b0;
    core_error_code_i = '0;
    if (!rst_ni) begin
      res_q.delete();
      wait_cnt = -1;
    end else begin
      if (do_pop && res_q.size() > 0) void'(res_q.pop_front());
      if (do_start) begin
        pix_no++;
        wait_cnt = core_lat;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0 && !withhold) begin
          core_pixel_done_i = 1'b1;
          if (pix_no == err_pix) core_error_code_i = err_val;
          else for (int k = 0; k < out_words_m; k++) begin
            w = $urandom;
            res_q.push_back(w);
            exp_out_q.push_back(w);
          end
        end
      end
    end
    core_out_valid_i = (res_q.size() > 0);
    core_out_data_i  = core_out_valid_i ? res_q[0] : '0;
  end

  function automatic int diff_in();
    int n = 0;
    if (push_q.size() != exp_in_q.size()) return -1;
    foreach (push_q[i]) if (push_q[i] !== exp_in_q[i]) n++;
    return n;
  endfunction

  function automatic int diff_out();
    int n = 0;
    if (beat_q.size() != exp_out_q.size()) return -1;
    foreach (beat_q[i]) if (beat_q[i] !== exp_out_q[i]) n++;
    return n;
  endfunction

  task automatic clear_model();
    push_q.delete(); beat_q.delete(); exp_out_q.delete();
    start_cnt = 0; done_cnt = 0; viol = 0; pix_no = 0;
    core_lat = 2; err_pix = 0; err_val = '0; withhold = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; job_start_i = 1'b0; abort_i = 1'b0;
    s_valid_i = 1'b0; s_data_i = '0; m_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    clear_model();
  endtask

  task automatic start_job(input logic [OW-1:0] op, input logic [BW-1:0] bands,
                           input int pix, input int inw, input int outw);
    @(posedge clk_i); #1;
    op_code_i = op; num_bands_i = bands; num_pixels_i = PW'(pix);
    in_words_i = WW'(inw); out_words_i = WW'(outw); job_start_i = 1'b1;
    out_words_m = outw;
    exp_in_q.delete();
    for (int i = 0; i < pix * inw; i++) exp_in_q.push_back($urandom);
    @(posedge clk_i); #1;
    job_start_i = 1'b0;
    // Config is don't-care after acceptance; scramble it to prove it was latched.
    op_code_i = OW'($urandom); num_bands_i = BW'($urandom); num_pixels_i = PW'($urandom);
    in_words_i = WW'($urandom); out_words_i = WW'($urandom);
  endtask

  task automatic run_stream(input bit rnd, input int budget, output bit ended,
                            output int t_start, output int t_end);
    int i = 0, cyc = 0;
    ended = 1'b0; t_start = -1; t_end = -1;
    while (!ended && cyc < budget) begin
      @(posedge clk_i); #1;
      s_valid_i = (i < exp_in_q.size()) && (!rnd || $urandom_range(0, 1) == 1);
      s_data_i  = s_valid_i ? exp_in_q[i] : '0;
      m_ready_i = !rnd || ($urandom_range(0, 1) == 1);
      @(negedge clk_i);
      cyc++;
      if (s_valid_i && s_ready_o) i++;
      if (core_start_o) t_start = cyc;
      if (!busy_o) begin ended = 1'b1; t_end = cyc; end
    end
    @(posedge clk_i); #1;
    s_valid_i = 1'b0; s_data_i = '0; m_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_reset();
    checks++; if ({busy_o, done_o, err_o, s_ready_o, m_valid_o, core_start_o, core_in_wr_en_o, core_out_rd_en_o} !== 8'h0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0", {busy_o, done_o, err_o, s_ready_o, m_valid_o, core_start_o, core_in_wr_en_o, core_out_rd_en_o}); end
    checks++; if (err_code_o !== '0) begin errors++; $display("FAIL reset_err_code: got %0h expected 0", err_code_o); end
    checks++; if (pixel_cnt_o !== '0) begin errors++; $display("FAIL reset_pixel_cnt: got %0d expected 0", pixel_cnt_o); end
    checks++; if ({core_op_code_o, core_num_bands_o} !== '0) begin errors++; $display("FAIL reset_cfg: got %0h expected 0", {core_op_code_o, core_num_bands_o}); end
  endtask

  task automatic test_basic(input bit rnd);
    bit ended; int ts, te;
    do_reset();
    core_lat = rnd ? int'($urandom_range(1, 8)) : 3;
    start_job(8'h3C, 8'd4, 3, 8, 1);
    run_stream(rnd, 2000, ended, ts, te);
    checks++; if (!ended) begin errors++; $display("FAIL basic_end(rnd=%0d): job still busy after budget", rnd); end
    checks++; if (push_q.size() != 24) begin errors++; $display("FAIL basic_pushes(rnd=%0d): got %0d expected 24", rnd, push_q.size()); end
    checks++; if (diff_in() != 0) begin errors++; $display("FAIL basic_in_data(rnd=%0d): %0d words differ, expected 0", rnd, diff_in()); end
    checks++; if (start_cnt != 3) begin errors++; $display("FAIL basic_starts(rnd=%0d): got %0d expected 3", rnd, start_cnt); end
    checks++; if (beat_q.size() != 3 || diff_out() != 0) begin errors++; $display("FAIL basic_out(rnd=%0d): beats %0d diff %0d expected 3/0", rnd, beat_q.size(), diff_out()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done(rnd=%0d): got %0d expected 1", rnd, done_cnt); end
    checks++; if (pixel_cnt_o !== 16'd3) begin errors++; $display("FAIL basic_pixel_cnt(rnd=%0d): got %0d expected 3", rnd, pixel_cnt_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL basic_err(rnd=%0d): got %b expected 0", rnd, err_o); end
    checks++; if ({core_op_code_o, core_num_bands_o} !== 16'h3C04) begin errors++; $display("FAIL basic_cfg(rnd=%0d): got %0h expected 3c04", rnd, {core_op_code_o, core_num_bands_o}); end
    checks++; if (viol != 0) begin errors++; $display("FAIL basic_handshake(rnd=%0d): %0d violations expected 0", rnd, viol); end
  endtask

  task automatic test_core_error();
    bit ended; int ts, te;
    do_reset();
    core_lat = $urandom_range(1, 8); err_pix = 2; err_val = 8'h05;
    start_job(8'h21, 8'd4, 3, 8, 1);
    run_stream(1'b0, 2000, ended, ts, te);
    checks++; if (!ended) begin errors++; $display("FAIL cerr_end: job still busy after budget"); end
    checks++; if (err_o !== 1'b1 || err_code_o !== 8'h05) begin errors++; $display("FAIL cerr_code: got err=%b code=%0h expected 1/05", err_o, err_code_o); end
    checks++; if (pixel_cnt_o !== 16'd1) begin errors++; $display("FAIL cerr_pixel_cnt: got %0d expected 1", pixel_cnt_o); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL cerr_done: got %0d expected 0", done_cnt); end
    checks++; if (start_cnt != 2 || push_q.size() != 16 || beat_q.size() != 1) begin errors++;
      $display("FAIL cerr_traffic: starts %0d pushes %0d beats %0d expected 2/16/1", start_cnt, push_q.size(), beat_q.size()); end
  endtask

  task automatic test_timeout();
    bit ended; int ts, te;
    do_reset();
    withhold = 1'b1;
    start_job(8'h11, 8'd2, 1, 2, 1);
    run_stream(1'b0, 200, ended, ts, te);
    checks++; if (!ended || te - ts != TO + 1) begin errors++; $display("FAIL timeout_delay: got %0d cycles expected %0d", te - ts, TO + 1); end
    checks++; if (err_o !== 1'b1 || err_code_o !== 8'hFE) begin errors++; $display("FAIL timeout_code: got err=%b code=%0h expected 1/fe", err_o, err_code_o); end
    checks++; if (done_cnt != 0 || start_cnt != 1) begin errors++; $display("FAIL timeout_counts: done %0d starts %0d expected 0/1", done_cnt, start_cnt); end
    // pixel_done arriving on the very cycle the timer expires must win
    do_reset();
    core_lat = TO - 1;
    start_job(8'h12, 8'd2, 1, 2, 1);
    run_stream(1'b0, 200, ended, ts, te);
    checks++; if (err_o !== 1'b0 || done_cnt != 1) begin errors++; $display("FAIL timeout_edge: got err=%b done=%0d expected 0/1", err_o, done_cnt); end
    checks++; if (diff_out() != 0 || beat_q.size() != 1) begin errors++; $display("FAIL timeout_edge_out: beats %0d diff %0d expected 1/0", beat_q.size(), diff_out()); end
  endtask

  task automatic test_bad_cfg();
    bit ended; int ts, te;
    do_reset();
    start_job(8'h01, 8'd1, 0, 4, 1);
    run_stream(1'b0, 20, ended, ts, te);
    checks++; if (err_o !== 1'b1 || err_code_o !== 8'hFF) begin errors++; $display("FAIL badcfg_pix: got err=%b code=%0h expected 1/ff", err_o, err_code_o); end
    checks++; if (start_cnt != 0 || push_q.size() != 0) begin errors++; $display("FAIL badcfg_pix_traffic: starts %0d pushes %0d expected 0/0", start_cnt, push_q.size()); end
    clear_model();
    start_job(8'h01, 8'd1, 2, 0, 1);
    run_stream(1'b0, 20, ended, ts, te);
    checks++; if (err_o !== 1'b1 || err_code_o !== 8'hFF || start_cnt != 0) begin errors++;
      $display("FAIL badcfg_words: got err=%b code=%0h starts=%0d expected 1/ff/0", err_o, err_code_o, start_cnt); end
  endtask

  // Runs straight on from the bad-config error, so the first job also proves err_o clears.
  task automatic test_back_to_back();
    bit ended; int ts, te, pix, inw, outw;
    for (int it = 0; it < 4; it++) begin
      clear_model();
      pix = $urandom_range(1, 4); inw = $urandom_range(1, 6); outw = $urandom_range(0, 3);
      core_lat = $urandom_range(1, 8);
      start_job(OW'($urandom), BW'($urandom), pix, inw, outw);
      run_stream(it[0], 3000, ended, ts, te);
      checks++; if (!ended || err_o !== 1'b0 || err_code_o !== '0) begin errors++;
        $display("FAIL b2b_status[%0d]: ended=%b err=%b code=%0h expected 1/0/0", it, ended, err_o, err_code_o); end
      checks++; if (diff_in() != 0 || diff_out() != 0 || beat_q.size() != pix * outw) begin errors++;
        $display("FAIL b2b_data[%0d]: in diff %0d out diff %0d beats %0d expected 0/0/%0d", it, diff_in(), diff_out(), beat_q.size(), pix * outw); end
      checks++; if (start_cnt != pix || done_cnt != 1 || pixel_cnt_o !== PW'(pix)) begin errors++;
        $display("FAIL b2b_counts[%0d]: starts %0d done %0d pixels %0d expected %0d/1/%0d", it, start_cnt, done_cnt, pixel_cnt_o, pix, pix); end
      checks++; if (viol != 0) begin errors++; $display("FAIL b2b_handshake[%0d]: %0d violations expected 0", it, viol); end
    end
  endtask

  task automatic test_abort();
    do_reset();
    start_job(8'h44, 8'd3, 2, 8, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1; s_valid_i = 1'b1; s_data_i = exp_in_q[i];
    end
    @(posedge clk_i); #1; abort_i = 1'b1; s_data_i = exp_in_q[3];
    @(negedge clk_i);
    checks++; if (core_in_wr_en_o !== 1'b0) begin errors++; $display("FAIL abort_push: got wr_en=%b expected 0", core_in_wr_en_o); end
    @(posedge clk_i); #1; abort_i = 1'b0; s_valid_i = 1'b0;
    @(negedge clk_i);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy_o); end
    repeat (5) @(negedge clk_i);
    checks++; if (err_o !== 1'b0 || done_cnt != 0 || start_cnt != 0 || push_q.size() != 3) begin errors++;
      $display("FAIL abort_quiet: err %b done %0d starts %0d pushes %0d expected 0/0/0/3", err_o, done_cnt, start_cnt, push_q.size()); end
  endtask

  task automatic test_reset_drain();
    bit ended, seen = 1'b0; int ts, te, i = 0;
    do_reset();
    start_job(8'hA5, 8'd7, 2, 2, 4);
    for (int c = 0; c < 200 && !seen; c++) begin
      @(posedge clk_i); #1;
      s_valid_i = (i < exp_in_q.size()); s_data_i = s_valid_i ? exp_in_q[i] : '0; m_ready_i = 1'b0;
      @(negedge clk_i);
      if (s_valid_i && s_ready_o) i++;
      if (m_valid_o) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstdrain_reach: DRAIN not reached within budget"); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if ({busy_o, done_o, err_o, s_ready_o, m_valid_o, core_start_o, core_in_wr_en_o, core_out_rd_en_o} !== 8'h0) begin
      errors++; $display("FAIL rstdrain_ctrl: got %b expected 0", {busy_o, done_o, err_o, s_ready_o, m_valid_o, core_start_o, core_in_wr_en_o, core_out_rd_en_o}); end
    checks++; if ({m_data_o, core_op_code_o, core_num_bands_o, err_code_o, pixel_cnt_o} !== '0) begin errors++;
      $display("FAIL rstdrain_data: got %0h expected 0", {m_data_o, core_op_code_o, core_num_bands_o, err_code_o, pixel_cnt_o}); end
    do_reset();
    start_job(8'h5A, 8'd2, 2, 3, 2);
    run_stream(1'b1, 2000, ended, ts, te);
    checks++; if (!ended || done_cnt != 1 || err_o !== 1'b0 || pixel_cnt_o !== 16'd2) begin errors++;
      $display("FAIL rstdrain_rerun: ended %b done %0d err %b pixels %0d expected 1/1/0/2", ended, done_cnt, err_o, pixel_cnt_o); end
    checks++; if (diff_in() != 0 || diff_out() != 0 || beat_q.size() != 4) begin errors++;
      $display("FAIL rstdrain_rerun_data: in diff %0d out diff %0d beats %0d expected 0/0/4", diff_in(), diff_out(), beat_q.size()); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clear_model();
    do_reset();
    @(negedge clk_i);
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_core_error();
    test_timeout();
    test_bad_cfg();
    test_back_to_back();
    test_abort();
    test_reset_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
